voice_allocator: RTL and testbench

Polyphonic voice scheduler for the 8-voice synth core. Accepts note-on/note-off events from the keyboard/MIDI front end over a valid/ready handshake and assigns each event to one of the voice slots. Drives per-voice KEY gates and FREQ note codes into the oscillator/envelope datapath, in place of software writing the key/frequency registers directly. Scans voices sequentially, reuses retriggered notes, and steals the oldest voice when all are busy.

---
 rtl/voice_allocator.sv | 164 ++++++++++++++++
 tb/tb_voice_allocator.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans voice slots one per cycle, then retriggers a matching note,
// takes the lowest free slot, or steals the oldest active voice.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned NOTE_W     = 7,
  parameter int unsigned AGE_W      = 8
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          EV_VALID,
  output logic                          EV_READY,
  input  logic                          EV_ON,
  input  logic [NOTE_W-1:0]             EV_NOTE,
  input  logic                          ALL_OFF,
  output logic [NUM_VOICES-1:0]         KEY,
  output logic [NUM_VOICES*NOTE_W-1:0]  FREQ,
  output logic                          ASSIGN_VALID,
  output logic [$clog2(NUM_VOICES)-1:0] ASSIGN_VOICE,
  output logic                          ASSIGN_HIT,
  output logic                          STEAL
);

  localparam int unsigned IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  state_e                  state;
  logic [NUM_VOICES-1:0]   voice_active;
  logic [NOTE_W-1:0]       voice_note [NUM_VOICES];
  logic [AGE_W-1:0]        voice_age  [NUM_VOICES];

  logic                    cap_on;
  logic [NOTE_W-1:0]       cap_note;
  logic [IDX_W-1:0]        idx;
  logic                    free_found, match_found, old_found;
  logic [IDX_W-1:0]        free_idx, match_idx, old_idx;
  logic [AGE_W-1:0]        old_age;

  logic [IDX_W-1:0]        target;
  logic                    do_steal;

  // Note-on target priority: retrigger, then lowest free slot, then oldest active voice.
  always_comb begin
    target   = old_idx;
    do_steal = 1'b0;
    if (match_found) begin
      target = match_idx;
    end else if (free_found) begin
      target = free_idx;
    end else begin
      do_steal = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= StIdle;
      voice_active <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_note[i] <= '0;
        voice_age[i]  <= '0;
      end
      cap_on       <= 1'b0;
      cap_note     <= '0;
      idx          <= '0;
      free_found   <= 1'b0;
      match_found  <= 1'b0;
      old_found    <= 1'b0;
      free_idx     <= '0;
      match_idx    <= '0;
      old_idx      <= '0;
      old_age      <= '0;
      ASSIGN_VALID <= 1'b0;
      ASSIGN_VOICE <= '0;
      ASSIGN_HIT   <= 1'b0;
      STEAL        <= 1'b0;
    end else begin
      ASSIGN_VALID <= 1'b0;
      STEAL        <= 1'b0;
      if (ALL_OFF) begin
        // Panic: gates and ages cleared, pitches kept for the release phase.
        voice_active <= '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
          voice_age[i] <= '0;
        end
        state <= StIdle;
      end else begin
        unique case (state)
          StIdle: begin
            if (EV_VALID) begin
              cap_on      <= EV_ON;
              cap_note    <= EV_NOTE;
              idx         <= '0;
              free_found  <= 1'b0;
              match_found <= 1'b0;
              old_found   <= 1'b0;
              free_idx    <= '0;
              match_idx   <= '0;
              old_idx     <= '0;
              old_age     <= '0;
              state       <= StScan;
            end
          end
          StScan: begin
            if (!voice_active[idx] && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= idx;
            end
            if (voice_active[idx] && (voice_note[idx] == cap_note) && !match_found) begin
              match_found <= 1'b1;
              match_idx   <= idx;
            end
            // Strict compare keeps the lowest index on age ties.
            if (voice_active[idx] && (!old_found || (voice_age[idx] > old_age))) begin
              old_found <= 1'b1;
              old_idx   <= idx;
              old_age   <= voice_age[idx];
            end
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state <= StCommit;
            end
          end
          StCommit: begin
            ASSIGN_VALID <= 1'b1;
            state        <= StIdle;
            if (cap_on) begin
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == target) begin
                  voice_active[i] <= 1'b1;
                  voice_note[i]   <= cap_note;
                  voice_age[i]    <= '0;
                end else if (voice_active[i] && (voice_age[i] != AGE_MAX)) begin
                  voice_age[i] <= voice_age[i] + 1'b1;
                end
              end
              ASSIGN_VOICE <= target;
              ASSIGN_HIT   <= 1'b1;
              STEAL        <= do_steal;
            end else if (match_found) begin
              voice_active[match_idx] <= 1'b0;
              ASSIGN_VOICE            <= match_idx;
              ASSIGN_HIT              <= 1'b1;
            end else begin
              ASSIGN_VOICE <= '0;
              ASSIGN_HIT   <= 1'b0;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

  assign EV_READY = (state == StIdle);
  assign KEY      = voice_active;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_freq
    assign FREQ[NOTE_W*g +: NOTE_W] = voice_note[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios plus random events checked against a
// slot-level model of allocation, retrigger, release and oldest-voice stealing.
module tb_voice_allocator;

  localparam int NV = 8;
  localparam int NW = 7;
  localparam int AMAX = 255;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic             EV_VALID = 1'b0;
  logic             EV_READY;
  logic             EV_ON = 1'b0;
  logic [NW-1:0]    EV_NOTE = '0;
  logic             ALL_OFF = 1'b0;
  logic [NV-1:0]    KEY;
  logic [NV*NW-1:0] FREQ;
  logic             ASSIGN_VALID;
  logic [2:0]       ASSIGN_VOICE;
  logic             ASSIGN_HIT;
  logic             STEAL;

  voice_allocator #(.NUM_VOICES(NV), .NOTE_W(NW), .AGE_W(8)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .EV_VALID     (EV_VALID),
    .EV_READY     (EV_READY),
    .EV_ON        (EV_ON),
    .EV_NOTE      (EV_NOTE),
    .ALL_OFF      (ALL_OFF),
    .KEY          (KEY),
    .FREQ         (FREQ),
    .ASSIGN_VALID (ASSIGN_VALID),
    .ASSIGN_VOICE (ASSIGN_VOICE),
    .ASSIGN_HIT   (ASSIGN_HIT),
    .STEAL        (STEAL)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: plain per-slot arrays.
  int m_act [NV];
  int m_note[NV];
  int m_age [NV];
  int exp_voice;
  bit exp_hit, exp_steal;

  bit               obs_ready, obs_early, obs_valid, obs_hit, obs_steal, obs_ready_after;
  logic [2:0]       obs_voice;
  logic [NV-1:0]    obs_key;
  logic [NV*NW-1:0] obs_freq;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic void model_event(input bit on, input int note);
    int match = -1, free = -1, old = -1, old_age = -1, tgt;
    for (int i = 0; i < NV; i++) begin
      if (m_act[i] != 0 && m_note[i] == note && match < 0) match = i;
      if (m_act[i] == 0 && free < 0) free = i;
      if (m_act[i] != 0 && m_age[i] > old_age) begin old = i; old_age = m_age[i]; end
    end
    exp_steal = 1'b0;
    if (on) begin
      tgt = (match >= 0) ? match : (free >= 0) ? free : old;
      exp_steal = (match < 0 && free < 0);
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_act[i] != 0 && m_age[i] < AMAX) m_age[i]++;
      m_act[tgt] = 1; m_note[tgt] = note; m_age[tgt] = 0;
      exp_voice = tgt; exp_hit = 1'b1;
    end else if (match >= 0) begin
      m_act[match] = 0;
      exp_voice = match; exp_hit = 1'b1;
    end else begin
      exp_voice = 0; exp_hit = 1'b0;
    end
  endfunction

  function automatic logic [NV-1:0] model_key();
    logic [NV-1:0] k = '0;
    for (int i = 0; i < NV; i++) k[i] = (m_act[i] != 0);
    return k;
  endfunction

  function automatic logic [NV*NW-1:0] model_freq();
    logic [NV*NW-1:0] f = '0;
    for (int i = 0; i < NV; i++) f[NW*i +: NW] = NW'(m_note[i]);
    return f;
  endfunction

  // Called at a negedge; presents one event, returns at the negedge after its commit edge.
  task automatic do_event(input bit on, input int note);
    obs_ready = EV_READY;
    EV_ON = on; EV_NOTE = NW'(note); EV_VALID = 1'b1;
    @(posedge CLK); #1;
    EV_VALID = 1'b0;
    obs_early = 1'b0;
    for (int c = 0; c < NV + 1; c++) begin
      @(negedge CLK);
      if (ASSIGN_VALID) obs_early = 1'b1;
    end
    @(negedge CLK);
    obs_valid = ASSIGN_VALID; obs_voice = ASSIGN_VOICE; obs_hit = ASSIGN_HIT;
    obs_steal = STEAL; obs_key = KEY; obs_freq = FREQ; obs_ready_after = EV_READY;
  endtask

  task automatic apply_reset();
    RESET = 1'b1; EV_VALID = 1'b0; ALL_OFF = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  task automatic fill_60_67();
    for (int i = 0; i < NV; i++) begin
      do_event(1'b1, 60 + i);
      model_event(1'b1, 60 + i);
      n_cmp++;
      if (obs_voice !== 3'(i)) begin
        n_fail++; $display("FAIL fill voice %0d: got %0d want %0d", i, obs_voice, i);
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; EV_VALID = 1'b1; EV_ON = 1'b1; EV_NOTE = 7'd60;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0; EV_VALID = 1'b0;
    model_reset();
    n_cmp++;
    if (KEY !== 8'h00 || FREQ !== '0) begin
      n_fail++; $display("FAIL reset key/freq: got %h/%h want 0/0", KEY, FREQ);
    end
    n_cmp++;
    if ({ASSIGN_VALID, ASSIGN_VOICE, ASSIGN_HIT, STEAL} !== 6'b0) begin
      n_fail++; $display("FAIL reset assign: got %b want 000000",
                         {ASSIGN_VALID, ASSIGN_VOICE, ASSIGN_HIT, STEAL});
    end
    n_cmp++;
    if (EV_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset ready: got %b want 1", EV_READY);
    end
    repeat (3) @(negedge CLK);
    n_cmp++;
    if (EV_READY !== 1'b1 || KEY !== 8'h00) begin
      n_fail++; $display("FAIL reset event ignored: ready %b key %h want 1 00", EV_READY, KEY);
    end
  endtask

  task automatic test_single_note();
    do_event(1'b1, 60);
    model_event(1'b1, 60);
    n_cmp++;
    if (obs_early !== 1'b0 || obs_valid !== 1'b1) begin
      n_fail++; $display("FAIL single latency: early %b valid %b want 0 1", obs_early, obs_valid);
    end
    n_cmp++;
    if (obs_voice !== 3'd0 || obs_hit !== 1'b1 || obs_steal !== 1'b0) begin
      n_fail++; $display("FAIL single assign: voice %0d hit %b steal %b want 0 1 0",
                         obs_voice, obs_hit, obs_steal);
    end
    n_cmp++;
    if (obs_key !== 8'h01 || obs_freq[6:0] !== 7'd60) begin
      n_fail++; $display("FAIL single key/freq: got %h/%0d want 01/60", obs_key, obs_freq[6:0]);
    end
    n_cmp++;
    if (obs_ready !== 1'b1 || obs_ready_after !== 1'b1) begin
      n_fail++; $display("FAIL single ready: before %b after %b want 1 1", obs_ready,
                         obs_ready_after);
    end
  endtask

  task automatic test_steal();
    apply_reset();
    fill_60_67();
    do_event(1'b1, 70);
    model_event(1'b1, 70);
    n_cmp++;
    if (obs_steal !== 1'b1 || obs_voice !== 3'd0) begin
      n_fail++; $display("FAIL steal: steal %b voice %0d want 1 0", obs_steal, obs_voice);
    end
    n_cmp++;
    if (obs_key !== 8'hFF || obs_freq[6:0] !== 7'd70) begin
      n_fail++; $display("FAIL steal key/freq: got %h/%0d want ff/70", obs_key, obs_freq[6:0]);
    end
    n_cmp++;
    if (dut.voice_age[1] !== 8'd7) begin
      n_fail++; $display("FAIL steal age1: got %0d want 7", dut.voice_age[1]);
    end
  endtask

  task automatic test_note_off();
    apply_reset();
    fill_60_67();
    do_event(1'b0, 62);
    model_event(1'b0, 62);
    n_cmp++;
    if (obs_key !== 8'hFB || obs_freq[20:14] !== 7'd62 || obs_voice !== 3'd2 || !obs_hit) begin
      n_fail++; $display("FAIL note-off: key %h freq2 %0d voice %0d hit %b want fb 62 2 1",
                         obs_key, obs_freq[20:14], obs_voice, obs_hit);
    end
    do_event(1'b1, 80);
    model_event(1'b1, 80);
    n_cmp++;
    if (obs_key !== 8'hFF || obs_voice !== 3'd2 || obs_steal !== 1'b0) begin
      n_fail++; $display("FAIL refill: key %h voice %0d steal %b want ff 2 0",
                         obs_key, obs_voice, obs_steal);
    end
    do_event(1'b0, 99);
    model_event(1'b0, 99);
    n_cmp++;
    if (obs_valid !== 1'b1 || obs_hit !== 1'b0 || obs_voice !== 3'd0) begin
      n_fail++; $display("FAIL unmatched off: valid %b hit %b voice %0d want 1 0 0",
                         obs_valid, obs_hit, obs_voice);
    end
    n_cmp++;
    if (obs_key !== model_key() || obs_freq !== model_freq()) begin
      n_fail++; $display("FAIL unmatched off state: key %h freq %h want %h %h",
                         obs_key, obs_freq, model_key(), model_freq());
    end
  endtask

  task automatic test_retrigger();
    apply_reset();
    for (int n = 60; n < 64; n++) begin
      do_event(1'b1, n);
      model_event(1'b1, n);
    end
    n_cmp++;
    if (dut.voice_age[0] !== 8'd3) begin
      n_fail++; $display("FAIL retrigger pre-age: got %0d want 3", dut.voice_age[0]);
    end
    do_event(1'b1, 60);
    model_event(1'b1, 60);
    n_cmp++;
    if (obs_voice !== 3'd0 || obs_steal !== 1'b0 || obs_key !== 8'h0F) begin
      n_fail++; $display("FAIL retrigger: voice %0d steal %b key %h want 0 0 0f",
                         obs_voice, obs_steal, obs_key);
    end
    n_cmp++;
    if (dut.voice_age[0] !== 8'd0) begin
      n_fail++; $display("FAIL retrigger age: got %0d want 0", dut.voice_age[0]);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int n = 40; n < 44; n++) begin
      do_event(1'b1, n);
      model_event(1'b1, n);
    end
    for (int k = 0; k < 300; k++) begin
      do_event(1'b1, 50 + (k % 2));
      model_event(1'b1, 50 + (k % 2));
      n_cmp++;
      if (obs_valid !== 1'b1 || obs_voice !== 3'(exp_voice)) begin
        n_fail++; $display("FAIL sat event %0d: valid %b voice %0d want 1 %0d",
                           k, obs_valid, obs_voice, exp_voice);
      end
    end
    n_cmp++;
    if (dut.voice_age[0] !== 8'd255 || dut.voice_age[3] !== 8'd255) begin
      n_fail++; $display("FAIL sat age: v0 %0d v3 %0d want 255 255",
                         dut.voice_age[0], dut.voice_age[3]);
    end
    for (int n = 52; n < 54; n++) begin
      do_event(1'b1, n);
      model_event(1'b1, n);
    end
    do_event(1'b1, 54);
    model_event(1'b1, 54);
    n_cmp++;
    if (obs_steal !== 1'b1 || obs_voice !== 3'd0 || obs_key !== 8'hFF) begin
      n_fail++; $display("FAIL sat steal: steal %b voice %0d key %h want 1 0 ff",
                         obs_steal, obs_voice, obs_key);
    end
  endtask

  task automatic start_event_and_wait_scan();
    EV_ON = 1'b1; EV_NOTE = 7'd5; EV_VALID = 1'b1;
    @(posedge CLK); #1;
    EV_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_all_off();
    logic [NV*NW-1:0] freq_before;
    bit               seen;
    apply_reset();
    fill_60_67();
    freq_before = FREQ;
    start_event_and_wait_scan();
    ALL_OFF = 1'b1;
    @(negedge CLK);
    ALL_OFF = 1'b0;
    for (int i = 0; i < NV; i++) begin m_act[i] = 0; m_age[i] = 0; end
    n_cmp++;
    if (KEY !== 8'h00 || ASSIGN_VALID !== 1'b0 || EV_READY !== 1'b1) begin
      n_fail++; $display("FAIL all_off: key %h valid %b ready %b want 00 0 1",
                         KEY, ASSIGN_VALID, EV_READY);
    end
    n_cmp++;
    if (FREQ !== freq_before) begin
      n_fail++; $display("FAIL all_off freq: got %h want %h", FREQ, freq_before);
    end
    seen = 1'b0;
    for (int c = 0; c < NV + 4; c++) begin
      @(negedge CLK);
      if (ASSIGN_VALID) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || dut.voice_age[1] !== 8'd0) begin
      n_fail++; $display("FAIL all_off dropped: late valid %b age1 %0d want 0 0",
                         seen, dut.voice_age[1]);
    end
  endtask

  task automatic test_reset_mid_scan();
    bit seen;
    apply_reset();
    fill_60_67();
    start_event_and_wait_scan();
    RESET = 1'b1;
    #1;
    n_cmp++;
    if (KEY !== 8'h00 || FREQ !== '0 || EV_READY !== 1'b1 ||
        {ASSIGN_VALID, ASSIGN_VOICE, ASSIGN_HIT, STEAL} !== 6'b0) begin
      n_fail++; $display("FAIL reset mid-scan: key %h freq %h ready %b assign %b want 0 0 1 0",
                         KEY, FREQ, EV_READY, {ASSIGN_VALID, ASSIGN_VOICE, ASSIGN_HIT, STEAL});
    end
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    seen = 1'b0;
    for (int c = 0; c < NV + 4; c++) begin
      @(negedge CLK);
      if (ASSIGN_VALID) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL reset mid-scan event lost: late valid %b want 0", seen);
    end
  endtask

  task automatic test_random();
    bit on;
    int note;
    apply_reset();
    for (int k = 0; k < 150; k++) begin
      on   = ($urandom_range(0, 99) < 60);
      note = $urandom_range(0, 11);
      do_event(on, note);
      model_event(on, note);
      n_cmp++;
      if (obs_ready !== 1'b1 || obs_early !== 1'b0 || obs_valid !== 1'b1) begin
        n_fail++; $display("FAIL rand %0d handshake: ready %b early %b valid %b want 1 0 1",
                           k, obs_ready, obs_early, obs_valid);
      end
      n_cmp++;
      if (obs_voice !== 3'(exp_voice) || obs_hit !== exp_hit || obs_steal !== exp_steal) begin
        n_fail++; $display("FAIL rand %0d assign: voice %0d hit %b steal %b want %0d %b %b",
                           k, obs_voice, obs_hit, obs_steal, exp_voice, exp_hit, exp_steal);
      end
      n_cmp++;
      if (obs_key !== model_key() || obs_freq !== model_freq()) begin
        n_fail++; $display("FAIL rand %0d state: key %h freq %h want %h %h",
                           k, obs_key, obs_freq, model_key(), model_freq());
      end
      for (int i = 0; i < NV; i++) begin
        n_cmp++;
        if (dut.voice_age[i] !== 8'(m_age[i])) begin
          n_fail++; $display("FAIL rand %0d age%0d: got %0d want %0d",
                             k, i, dut.voice_age[i], m_age[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_steal();
    test_note_off();
    test_retrigger();
    test_saturation();
    test_all_off();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
